// File: rtl/plic_core_mc.sv
// Multi-context PLIC core: pending latch, per-source priority, per-context enable,
// threshold, registered arbitration and claim/complete over a word-addressed bus.
module plic_core_mc #(
  parameter int NUM_SOURCES     = 31,
  parameter int NUM_CONTEXTS    = 2,
  parameter int PRIORITY_WIDTH  = 3,
  parameter int SOURCE_ID_WIDTH = $clog2(NUM_SOURCES + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [23:0]                wb_addr_i,
  input  logic [31:0]                wb_wdata_i,
  input  logic                       wb_write_i,
  input  logic                       wb_read_i,
  input  logic [3:0]                 wb_sel_i,
  output logic [31:0]                wb_rdata_o,
  input  logic [NUM_SOURCES-1:0]     gateway_pending,
  output logic                       complete_valid_o,
  output logic [SOURCE_ID_WIDTH-1:0] complete_id_o,
  output logic [NUM_CONTEXTS-1:0]    irq_o
);

  localparam int NUM_WORDS = (NUM_SOURCES + 32) / 32;
  localparam int IPW       = NUM_WORDS * 32;
  // Bit 0 (reserved ID) and bits beyond the last source never hold state.
  localparam logic [IPW-1:0] SRC_MASK = ~({IPW{1'b1}} << (NUM_SOURCES + 1)) & ~IPW'(1);

  logic [PRIORITY_WIDTH-1:0]  prio_q      [1:NUM_SOURCES];
  logic [PRIORITY_WIDTH-1:0]  prio_d      [1:NUM_SOURCES];
  logic [IPW-1:0]             ip_q, ip_d, ip_clr;
  logic [IPW-1:0]             en_q        [NUM_CONTEXTS];
  logic [IPW-1:0]             en_d        [NUM_CONTEXTS];
  logic [PRIORITY_WIDTH-1:0]  thr_q       [NUM_CONTEXTS];
  logic [PRIORITY_WIDTH-1:0]  thr_d       [NUM_CONTEXTS];
  logic [SOURCE_ID_WIDTH-1:0] best_id_q   [NUM_CONTEXTS];
  logic [SOURCE_ID_WIDTH-1:0] best_id_d   [NUM_CONTEXTS];
  logic [PRIORITY_WIDTH-1:0]  best_prio_q [NUM_CONTEXTS];
  logic [PRIORITY_WIDTH-1:0]  best_prio_d [NUM_CONTEXTS];

  logic [IPW-1:0]             best_onehot [NUM_CONTEXTS];
  logic [NUM_CONTEXTS-1:0]    claim_ok;
  logic [NUM_CONTEXTS-1:0]    complete_ok;
  logic [SOURCE_ID_WIDTH-1:0] wr_id;
  logic [IPW-1:0]             wr_onehot;
  logic                       wr_id_ok;
  logic [31:0]                rdata;

  logic [11:0] page;
  logic [9:0]  word_idx;
  logic [23:0] en_off;
  logic [23:0] ctx_off;
  logic        en_region;
  logic        ctx_region;
  logic        unused_bits;

  assign page       = wb_addr_i[23:12];
  assign word_idx   = wb_addr_i[11:2];
  assign en_off     = wb_addr_i - 24'h002000;
  assign ctx_off    = wb_addr_i - 24'h200000;
  assign en_region  = (wb_addr_i[23:21] == 3'd0) && (wb_addr_i[20:13] != 8'd0);
  assign ctx_region = (wb_addr_i[23:21] != 3'd0);
  assign unused_bits = ^{wb_addr_i[1:0], en_off[23:21], en_off[1:0], ctx_off[1:0]};

  assign wr_id     = wb_wdata_i[SOURCE_ID_WIDTH-1:0];
  assign wr_onehot = IPW'(1) << wr_id;
  assign wr_id_ok  = (wr_id != '0) && (32'(wr_id) <= NUM_SOURCES);

  // The registered winner may be stale (another context claimed it), so recheck it live.
  for (genvar gi = 0; gi < NUM_CONTEXTS; gi++) begin : g_ctx
    assign best_onehot[gi] = IPW'(1) << best_id_q[gi];
    assign claim_ok[gi]    = |(ip_q & en_q[gi] & best_onehot[gi]);
    assign complete_ok[gi] = wr_id_ok && (|(en_q[gi] & wr_onehot));
    assign irq_o[gi]       = best_prio_q[gi] > thr_q[gi];
  end

  always_comb begin
    prio_d           = prio_q;
    en_d             = en_q;
    thr_d            = thr_q;
    ip_clr           = '0;
    rdata            = '0;
    complete_valid_o = 1'b0;
    complete_id_o    = '0;

    if (page == 12'h000) begin
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        if (32'(word_idx) == i) begin
          if (wb_read_i) rdata = 32'(prio_q[i]);
          if (wb_write_i && wb_sel_i[0]) prio_d[i] = wb_wdata_i[PRIORITY_WIDTH-1:0];
        end
      end
    end

    if (page == 12'h001 && wb_read_i) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (32'(word_idx) == w) rdata = ip_q[w*32 +: 32];
      end
    end

    if (en_region) begin
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        for (int w = 0; w < NUM_WORDS; w++) begin
          if (32'(en_off[20:7]) == c && 32'(en_off[6:2]) == w) begin
            if (wb_read_i) rdata = en_q[c][w*32 +: 32];
            if (wb_write_i) begin
              for (int b = 0; b < 4; b++) begin
                if (wb_sel_i[b]) en_d[c][w*32 + b*8 +: 8] = wb_wdata_i[b*8 +: 8];
              end
            end
          end
        end
      end
    end

    if (ctx_region) begin
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        if (32'(ctx_off[23:12]) == c) begin
          if (ctx_off[11:2] == 10'd0) begin
            if (wb_read_i) rdata = 32'(thr_q[c]);
            if (wb_write_i && wb_sel_i[0]) thr_d[c] = wb_wdata_i[PRIORITY_WIDTH-1:0];
          end else if (ctx_off[11:2] == 10'd1) begin
            if (wb_read_i && claim_ok[c]) begin
              rdata  = 32'(best_id_q[c]);
              ip_clr = best_onehot[c];
            end
            if (wb_write_i && complete_ok[c]) begin
              complete_valid_o = 1'b1;
              complete_id_o    = wr_id;
            end
          end
        end
      end
    end

    for (int c = 0; c < NUM_CONTEXTS; c++) begin
      en_d[c] = en_d[c] & SRC_MASK;
    end
  end

  assign wb_rdata_o = rdata;

  // A gateway set in the same cycle as a claim clear keeps the source pending.
  assign ip_d = ((ip_q & ~ip_clr) | IPW'({gateway_pending, 1'b0})) & SRC_MASK;

  // Strictly-greater scan from ID 1 upward keeps the lowest ID on a priority tie.
  always_comb begin
    for (int c = 0; c < NUM_CONTEXTS; c++) begin
      best_prio_d[c] = '0;
      best_id_d[c]   = '0;
      for (int i = 1; i <= NUM_SOURCES; i++) begin
        if (ip_q[i] && en_q[c][i] && (prio_q[i] > best_prio_d[c])) begin
          best_prio_d[c] = prio_q[i];
          best_id_d[c]   = SOURCE_ID_WIDTH'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ip_q <= '0;
      for (int i = 1; i <= NUM_SOURCES; i++) prio_q[i] <= '0;
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        en_q[c]        <= '0;
        thr_q[c]       <= '0;
        best_id_q[c]   <= '0;
        best_prio_q[c] <= '0;
      end
    end else begin
      ip_q   <= ip_d;
      prio_q <= prio_d;
      for (int c = 0; c < NUM_CONTEXTS; c++) begin
        en_q[c]        <= en_d[c];
        thr_q[c]       <= thr_d[c];
        best_id_q[c]   <= best_id_d[c];
        best_prio_q[c] <= best_prio_d[c];
      end
    end
  end

endmodule

// File: tb/tb_plic_core_mc.sv
// Directed bench for plic_core_mc: each task drives one scenario and checks inline.
module tb_plic_core_mc;
  localparam int SIW = 5;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [23:0]    wb_addr_i = '0;
  logic [31:0]    wb_wdata_i = '0;
  logic           wb_write_i = 1'b0;
  logic           wb_read_i = 1'b0;
  logic [3:0]     wb_sel_i = '0;
  logic [31:0]    wb_rdata_o;
  logic [30:0]    gateway_pending = '0;
  logic           complete_valid_o;
  logic [SIW-1:0] complete_id_o;
  logic [1:0]     irq_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  plic_core_mc dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_addr_i        (wb_addr_i),
    .wb_wdata_i       (wb_wdata_i),
    .wb_write_i       (wb_write_i),
    .wb_read_i        (wb_read_i),
    .wb_sel_i         (wb_sel_i),
    .wb_rdata_o       (wb_rdata_o),
    .gateway_pending  (gateway_pending),
    .complete_valid_o (complete_valid_o),
    .complete_id_o    (complete_id_o),
    .irq_o            (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Bus tasks start at a negedge, hold the strobe across one posedge, end at the next negedge.
  task automatic bus_wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic cv, output logic [SIW-1:0] cid);
    wb_addr_i = a; wb_wdata_i = d; wb_sel_i = s; wb_write_i = 1'b1;
    #1;
    cv = complete_valid_o; cid = complete_id_o;
    @(negedge clk);
    wb_write_i = 1'b0; wb_sel_i = '0; wb_wdata_i = '0; wb_addr_i = '0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
    logic cv;
    logic [SIW-1:0] cid;
    bus_wr(a, d, s, cv, cid);
  endtask

  task automatic rd(input logic [23:0] a, output logic [31:0] d);
    wb_addr_i = a; wb_read_i = 1'b1;
    #1;
    d = wb_rdata_o;
    @(negedge clk);
    wb_read_i = 1'b0; wb_addr_i = '0;
  endtask

  task automatic pulse(input logic [30:0] mask);
    gateway_pending = mask;
    @(negedge clk);
    gateway_pending = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    idle(2);
    total_cnt++; if (irq_o !== 2'b00) $display("FAIL reset_irq: got %b want 00", irq_o); else pass_cnt++;
    total_cnt++; if (complete_valid_o !== 1'b0 || complete_id_o !== 5'd0)
      $display("FAIL reset_complete: got %b/%0d want 0/0", complete_valid_o, complete_id_o); else pass_cnt++;
    rst_n = 1'b1;
    idle(1);
    rd(24'h000014, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL reset_prio5: got %h want 0", d); else pass_cnt++;
    rd(24'h002000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL reset_en0: got %h want 0", d); else pass_cnt++;
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL reset_claim0: got %h want 0", d); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_pend_irq();
    logic [31:0] d;
    logic cv;
    logic [SIW-1:0] cid;
    wr(24'h000014, 32'd3, 4'h1);
    wr(24'h002000, 32'h20, 4'hF);
    wr(24'h200000, 32'd0, 4'h1);
    idle(2);
    pulse(31'd1 << 4);
    total_cnt++; if (irq_o !== 2'b00) $display("FAIL irq_n1: got %b want 00", irq_o); else pass_cnt++;
    idle(1);
    total_cnt++; if (irq_o !== 2'b01) $display("FAIL irq_n2: got %b want 01", irq_o); else pass_cnt++;
    rd(24'h001000, d);
    total_cnt++; if (d !== 32'h20) $display("FAIL pending_src5: got %h want 20", d); else pass_cnt++;
    rd(24'h000014, d);
    total_cnt++; if (d !== 32'd3) $display("FAIL prio5_read: got %h want 3", d); else pass_cnt++;
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd5) $display("FAIL claim5: got %0d want 5", d); else pass_cnt++;
    idle(2);
    total_cnt++; if (irq_o !== 2'b00) $display("FAIL irq_after_claim: got %b want 00", irq_o); else pass_cnt++;
    bus_wr(24'h200004, 32'd5, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b1 || cid !== 5'd5)
      $display("FAIL complete5: got %b/%0d want 1/5", cv, cid); else pass_cnt++;
    $display("test_pend_irq done");
  endtask

  task automatic test_tie_threshold();
    logic [31:0] d;
    wr(24'h00000C, 32'd4, 4'h1);
    wr(24'h00001C, 32'd4, 4'h1);
    wr(24'h002000, 32'h88, 4'hF);
    wr(24'h200000, 32'd3, 4'h1);
    pulse((31'd1 << 2) | (31'd1 << 6));
    idle(2);
    total_cnt++; if (irq_o !== 2'b01) $display("FAIL tie_irq: got %b want 01", irq_o); else pass_cnt++;
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd3) $display("FAIL tie_claim_first: got %0d want 3", d); else pass_cnt++;
    idle(1);
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd7) $display("FAIL tie_claim_second: got %0d want 7", d); else pass_cnt++;
    idle(1);
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL tie_claim_empty: got %0d want 0", d); else pass_cnt++;
    pulse(31'd1 << 2);
    wr(24'h200000, 32'd4, 4'h1);
    idle(2);
    total_cnt++; if (irq_o !== 2'b00) $display("FAIL thr_masks_irq: got %b want 00", irq_o); else pass_cnt++;
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd3) $display("FAIL thr_claim: got %0d want 3", d); else pass_cnt++;
    $display("test_tie_threshold done");
  endtask

  task automatic test_cross_context();
    logic [31:0] d0, d1, p;
    wr(24'h000024, 32'd2, 4'h1);
    wr(24'h002000, 32'h200, 4'hF);
    wr(24'h002080, 32'h200, 4'hF);
    wr(24'h200000, 32'd0, 4'h1);
    pulse(31'd1 << 8);
    idle(2);
    total_cnt++; if (irq_o !== 2'b11) $display("FAIL cross_irq: got %b want 11", irq_o); else pass_cnt++;
    rd(24'h200004, d0);
    rd(24'h201004, d1);
    total_cnt++; if (d0 !== 32'd9) $display("FAIL cross_claim_ctx0: got %0d want 9", d0); else pass_cnt++;
    total_cnt++; if (d1 !== 32'd0) $display("FAIL cross_claim_ctx1: got %0d want 0", d1); else pass_cnt++;
    rd(24'h001000, p);
    total_cnt++; if (p !== 32'd0) $display("FAIL cross_pending: got %h want 0", p); else pass_cnt++;
    $display("test_cross_context done");
  endtask

  task automatic test_complete();
    logic cv;
    logic [SIW-1:0] cid;
    bus_wr(24'h201004, 32'd9, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b1 || cid !== 5'd9)
      $display("FAIL complete9: got %b/%0d want 1/9", cv, cid); else pass_cnt++;
    #1;
    total_cnt++; if (complete_valid_o !== 1'b0 || complete_id_o !== 5'd0)
      $display("FAIL complete_one_cycle: got %b/%0d want 0/0", complete_valid_o, complete_id_o); else pass_cnt++;
    wr(24'h002080, 32'd0, 4'hF);
    bus_wr(24'h201004, 32'd9, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b0 || cid !== 5'd0)
      $display("FAIL complete_disabled: got %b/%0d want 0/0", cv, cid); else pass_cnt++;
    wr(24'h002080, 32'hFFFFFFFF, 4'hF);
    bus_wr(24'h201004, 32'd0, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b0) $display("FAIL complete_id0: got %b want 0", cv); else pass_cnt++;
    bus_wr(24'h201004, 32'd32, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b0) $display("FAIL complete_id32: got %b want 0", cv); else pass_cnt++;
    bus_wr(24'h201004, 32'd31, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b1 || cid !== 5'd31)
      $display("FAIL complete_id31: got %b/%0d want 1/31", cv, cid); else pass_cnt++;
    $display("test_complete done");
  endtask

  task automatic test_map_edges();
    logic [31:0] d;
    logic cv;
    logic [SIW-1:0] cid;
    wr(24'h002000, 32'hFFFFFFFF, 4'hF);
    rd(24'h002000, d);
    total_cnt++; if (d !== 32'hFFFFFFFE) $display("FAIL en0_mask: got %h want fffffffe", d); else pass_cnt++;
    wr(24'h001000, 32'hFFFFFFFF, 4'hF);
    rd(24'h001000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL pending_ro: got %h want 0", d); else pass_cnt++;
    wr(24'h002100, 32'hFFFFFFFF, 4'hF);
    rd(24'h002100, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL en_ctx2: got %h want 0", d); else pass_cnt++;
    wr(24'h202000, 32'd7, 4'h1);
    rd(24'h202000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL thr_ctx2: got %h want 0", d); else pass_cnt++;
    bus_wr(24'h202004, 32'd9, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b0) $display("FAIL complete_ctx2: got %b want 0", cv); else pass_cnt++;
    wr(24'h000000, 32'd7, 4'h1);
    rd(24'h000000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL prio0: got %h want 0", d); else pass_cnt++;
    rd(24'h002080, d);
    total_cnt++; if (d !== 32'hFFFFFFFE) $display("FAIL en1_unchanged: got %h want fffffffe", d); else pass_cnt++;
    rd(24'h200000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL thr0_unchanged: got %h want 0", d); else pass_cnt++;
    $display("test_map_edges done");
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(24'h000010, 32'd1, 4'h1);
    pulse(31'd1 << 3);
    idle(2);
    gateway_pending = 31'd1 << 3;
    wb_addr_i = 24'h200004; wb_read_i = 1'b1;
    #1;
    d = wb_rdata_o;
    @(negedge clk);
    wb_read_i = 1'b0; wb_addr_i = '0; gateway_pending = '0;
    total_cnt++; if (d !== 32'd4) $display("FAIL collide_claim: got %0d want 4", d); else pass_cnt++;
    rd(24'h001000, d);
    total_cnt++; if (d !== 32'h10) $display("FAIL collide_pending: got %h want 10", d); else pass_cnt++;
    rd(24'h200004, d);
    total_cnt++; if (d !== 32'd4) $display("FAIL collide_reclaim: got %0d want 4", d); else pass_cnt++;
    rd(24'h001000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL collide_cleared: got %h want 0", d); else pass_cnt++;
    $display("test_collision done");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic cv;
    logic [SIW-1:0] cid;
    pulse(31'd1 << 3);
    idle(2);
    total_cnt++; if (irq_o !== 2'b11) $display("FAIL pre_reset_irq: got %b want 11", irq_o); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (irq_o !== 2'b00) $display("FAIL mid_reset_irq: got %b want 00", irq_o); else pass_cnt++;
    @(negedge clk);
    bus_wr(24'h200004, 32'd4, 4'hF, cv, cid);
    total_cnt++; if (cv !== 1'b0) $display("FAIL mid_reset_complete: got %b want 0", cv); else pass_cnt++;
    rst_n = 1'b1;
    idle(1);
    rd(24'h000010, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL post_reset_prio4: got %h want 0", d); else pass_cnt++;
    rd(24'h001000, d);
    total_cnt++; if (d !== 32'd0) $display("FAIL post_reset_pending: got %h want 0", d); else pass_cnt++;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_pend_irq();
    test_tie_threshold();
    test_cross_context();
    test_complete();
    test_map_edges();
    test_collision();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
